spi_flash_slave: RTL and testbench

SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

---
 rtl/spi_flash_slave.sv | 114 +++++++++++
 tb/tb_spi_flash_slave.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/spi_flash_slave.sv
// spi_flash_slave: read-only SPI NOR flash model (SPI mode 0) serving READ, FAST READ,
// JEDEC ID, power-up (0xAB) and power-down (0xB9).
//
// Ports:
//   clk    - SPI serial clock; io0 is sampled on the rising edge, io1 changes on the falling edge
//   reset  - asynchronous active-high reset; clears transactions and powers the device down
//   csb    - active-low chip select; high asynchronously aborts the current transaction
//   io0    - MOSI, input only
//   io1    - MISO, high-Z outside data-output phases
//   io2/3  - unused, always high-Z
//
// Parameters:
//   FILENAME  - hex image (one byte per word, address 0 first); an empty string skips loading
//   MEM_BYTES - memory size in bytes, power of two; addresses are taken modulo this size
module spi_flash_slave #(
    parameter string FILENAME  = "firmware.hex",
    parameter int    MEM_BYTES = 16384
) (
    input  logic clk,
    input  logic reset,
    input  logic csb,
    inout  wire  io0,
    inout  wire  io1,
    inout  wire  io2,
    inout  wire  io3
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FAST  = 8'h0B;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_WAKE  = 8'hAB;
    localparam logic [7:0] CMD_SLEEP = 8'hB9;
    localparam logic [7:0] CMD_NONE  = 8'h00;

    logic [7:0]    mem [MEM_BYTES];
    logic [2:0]    bit_cnt;
    logic [3:0]    byte_cnt;
    logic [6:0]    shift_in;
    logic [7:0]    cmd;
    logic [AW-1:0] addr;
    logic          locked;
    logic          powered_up;
    logic          oe;
    logic [7:0]    out_sr;
    logic [7:0]    cmd_byte;
    logic          byte_end;
    logic          cmd_end;
    logic          rd_phase;
    logic          id_phase;
    logic [7:0]    tx_byte;

    always_comb begin
        cmd_byte = {shift_in, io0};
        byte_end = bit_cnt == 3'd7;
        cmd_end  = byte_end && byte_cnt == 4'd0;
        rd_phase = (cmd == CMD_READ && byte_cnt >= 4'd4) || (cmd == CMD_FAST && byte_cnt >= 4'd5);
        id_phase = cmd == CMD_JEDEC && byte_cnt >= 4'd1;
        tx_byte  = rd_phase ? mem[addr] :
                   byte_cnt == 4'd1 ? 8'hEF :
                   byte_cnt == 4'd2 ? 8'h40 :
                   byte_cnt == 4'd3 ? 8'h18 : 8'h00;
    end

    // Rising-edge transaction state. A reset seen while csb is low leaves the block locked
    // until csb rises, so a transaction cut by reset is never resumed mid-stream.
    always_ff @(posedge clk or posedge reset or posedge csb) begin
        if (reset || csb) begin
            bit_cnt  <= 3'd0;
            byte_cnt <= 4'd0;
            shift_in <= 7'd0;
            cmd      <= CMD_NONE;
            addr     <= '0;
            locked   <= reset && !csb;
        end else if (!locked) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= cmd_byte[6:0];
            if (byte_end && byte_cnt != 4'd8)
                byte_cnt <= byte_cnt + 4'd1;
            // While asleep only the wake command is latched; anything else becomes a no-op.
            if (cmd_end)
                cmd <= (powered_up || cmd_byte == CMD_WAKE) ? cmd_byte : CMD_NONE;
            // Only the low AW address bits are kept, which gives the modulo for free.
            if (byte_cnt >= 4'd1 && byte_cnt <= 4'd3)
                addr <= {addr[AW-2:0], io0};
            else if (rd_phase && byte_end)
                addr <= addr + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            powered_up <= 1'b0;
        else if (cmd_end)
            powered_up <= cmd_byte == CMD_WAKE  ? 1'b1 :
                          cmd_byte == CMD_SLEEP ? 1'b0 : powered_up;
    end

    // Falling-edge output shifter: a new byte is loaded at each byte boundary of a data phase.
    always_ff @(negedge clk or posedge reset or posedge csb) begin
        if (reset || csb) begin
            oe     <= 1'b0;
            out_sr <= 8'd0;
        end else if ((rd_phase || id_phase) && bit_cnt == 3'd0) begin
            oe     <= 1'b1;
            out_sr <= tx_byte;
        end else begin
            out_sr <= {out_sr[6:0], 1'b0};
        end
    end

    assign io1 = oe ? out_sr[7] : 1'bz;
    assign io2 = 1'bz;
    assign io3 = 1'bz;
endmodule

// File: tb/tb_spi_flash_slave.sv
// tb_spi_flash_slave: scoreboard bench for spi_flash_slave; io1 has a pull-up so a high-Z bus reads as 1
module tb_spi_flash_slave;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic csb = 1'b1;
    logic mosi = 1'b0;
    wire  io0, io1, io2, io3;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    assign io0 = mosi;
    pullup (io1);
    pullup (io2);
    pullup (io3);

    always #5 clk = ~clk;

    spi_flash_slave #(.FILENAME(""), .MEM_BYTES(16384)) dut (
        .clk(clk), .reset(reset), .csb(csb),
        .io0(io0), .io1(io1), .io2(io2), .io3(io3)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: assembles io1 bits sampled on rising edges into bytes and scores each one.
    initial begin
        logic [7:0] rx;
        int nb;
        rx = 8'd0;
        nb = 0;
        forever begin
            @(posedge clk);
            if (csb || reset) nb = 0;
            else begin
                rx = {rx[6:0], io1};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected: got byte %h, expected no byte", rx);
                    end else check(tag_q.pop_front(), rx, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            @(negedge clk);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic [7:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        send_bits(b, 8);
    endtask

    task automatic hdr(input logic [7:0] c, input logic [23:0] a, input string t);
        put(c, 8'hFF, {t, "_cmd"});
        put(a[23:16], 8'hFF, {t, "_a2"});
        put(a[15:8], 8'hFF, {t, "_a1"});
        put(a[7:0], 8'hFF, {t, "_a0"});
    endtask

    task automatic cs_low;
        @(negedge clk);
        csb = 1'b0;
    endtask

    task automatic cs_high;
        csb = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        dut.mem[16'h0010] = 8'h5A;
        dut.mem[16'h0011] = 8'hC3;
        dut.mem[16'h3FFF] = 8'h96;
        dut.mem[16'h0000] = 8'h3C;
        #12;
        check("reset_io1", {7'd0, io1}, 8'h01);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // asleep after reset: read ignored
        cs_low; hdr(8'h03, 24'h000010, "pd"); put(8'h00, 8'hFF, "pd_data"); cs_high;
        // wake and read two bytes
        cs_low; put(8'hAB, 8'hFF, "wake"); cs_high;
        cs_low; hdr(8'h03, 24'h000010, "rd"); put(8'h00, 8'h5A, "rd0"); put(8'h00, 8'hC3, "rd1"); cs_high;
        // wrap from last byte to 0
        cs_low; hdr(8'h03, 24'h003FFF, "wr"); put(8'h00, 8'h96, "wrap_hi"); put(8'h00, 8'h3C, "wrap_lo"); cs_high;
        // address above memory size is folded
        cs_low; hdr(8'h03, 24'h010011, "mod"); put(8'h00, 8'hC3, "mod_data"); cs_high;
        // fast read with dummy byte
        cs_low; hdr(8'h0B, 24'h000010, "fr"); put(8'h00, 8'hFF, "fr_dummy");
        put(8'h00, 8'h5A, "fr0"); put(8'h00, 8'hC3, "fr1"); cs_high;
        // JEDEC ID
        cs_low; put(8'h9F, 8'hFF, "id_cmd"); put(8'h00, 8'hEF, "id0"); put(8'h00, 8'h40, "id1");
        put(8'h00, 8'h18, "id2"); put(8'h00, 8'h00, "id3"); cs_high;
        // unknown command
        cs_low; put(8'h55, 8'hFF, "unk_cmd"); put(8'h00, 8'hFF, "unk_data"); cs_high;
        // abort mid-byte then clean restart
        cs_low; hdr(8'h03, 24'h000010, "ab"); send_bits(8'h00, 3); cs_high;
        cs_low; hdr(8'h03, 24'h000011, "rs"); put(8'h00, 8'hC3, "restart"); cs_high;
        // partial power-down byte has no effect
        cs_low; send_bits(8'hB9, 5); cs_high;
        cs_low; hdr(8'h03, 24'h000010, "pb"); put(8'h00, 8'h5A, "partial_b9"); cs_high;
        // power down, reads and ID ignored, wake restores
        cs_low; put(8'hB9, 8'hFF, "sleep"); cs_high;
        cs_low; hdr(8'h03, 24'h000010, "sl"); put(8'h00, 8'hFF, "slept_rd"); cs_high;
        cs_low; put(8'h9F, 8'hFF, "slept_id_cmd"); put(8'h00, 8'hFF, "slept_id"); cs_high;
        cs_low; put(8'hAB, 8'hFF, "rewake"); cs_high;
        cs_low; hdr(8'h03, 24'h000010, "rw"); put(8'h00, 8'h5A, "rewake_rd"); cs_high;
        // reset mid-read: io1 released at once, wake sent before csb rises is ignored
        cs_low; hdr(8'h03, 24'h000010, "mr");
        #2;
        check("mid_read_driven", {7'd0, io1}, 8'h00);
        reset = 1'b1;
        #1;
        check("mid_read_reset_hiz", {7'd0, io1}, 8'h01);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        put(8'hAB, 8'hFF, "locked_wake");
        cs_high;
        cs_low; hdr(8'h03, 24'h000010, "pr"); put(8'h00, 8'hFF, "post_reset_rd"); cs_high;
        cs_low; put(8'hAB, 8'hFF, "wake2"); cs_high;
        cs_low; hdr(8'h03, 24'h000011, "w2"); put(8'h00, 8'hC3, "wake2_rd"); cs_high;
        repeat (4) @(negedge clk);
        check("drain", 8'(exp_q.size()), 8'h00);
        check("io2_hiz", {7'd0, io2}, 8'h01);
        check("io3_hiz", {7'd0, io3}, 8'h01);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
